vga_rx_monitor: RTL and testbench

Receive-side checker for the VGA conduit driven by the Processor system (VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R/G/B). It samples the video stream on pixel strobes, measures line and frame geometry, folds active pixels into a per-frame signature, and reports lock status. It closes the loop on the video path for on-board self-test (status shown on LEDR) and for simulation benches.

---
 rtl/vga_mon_pkg.sv | 28 ++
 rtl/vga_line_meter.sv | 79 +++++++
 rtl/vga_rx_monitor.sv | 185 ++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_mon_pkg.sv
// Shared widths, 640x480@60 default geometry, FSM state type and counter helpers
// for the VGA receive-side monitor.
package vga_mon_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int DEF_H_TOTAL         = 800;
  localparam int DEF_H_ACTIVE        = 640;
  localparam int DEF_H_SYNC          = 96;
  localparam int DEF_V_TOTAL         = 525;
  localparam int DEF_V_ACTIVE        = 480;
  localparam int DEF_V_SYNC          = 2;
  localparam int DEF_SYNC_ACTIVE_LOW = 1;
  localparam int DEF_LOCK_FRAMES     = 2;

  typedef enum logic {SEARCH, MEASURE} mon_state_e;

  // Saturating increment; a saturated count is what the overflow logic keys on.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != CNT_MAX)) ? c + 1'b1 : c;
  endfunction

  function automatic logic [15:0] sig_step(input logic [15:0] sig, input logic [15:0] pix);
    return {sig[14:0], sig[15]} ^ pix;
  endfunction

endpackage

// File: rtl/vga_line_meter.sv
// Per-line pixel, hsync and active counters with line-complete checking,
// a sticky per-frame line_bad flag and the last completed line's measurements.
module vga_line_meter
  import vga_mon_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_SYNC   = DEF_H_SYNC
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_en,
  input  logic             i_hs_act,
  input  logic             i_hs_edge,
  input  logic             i_blank_n,
  input  logic             i_frame_clr,
  output logic             o_line_done,
  output logic             o_act_line,
  output logic             o_line_bad,
  output logic             o_h_ovf,
  output logic [CNT_W-1:0] o_last_h_total,
  output logic [CNT_W-1:0] o_last_h_active,
  output logic [CNT_W-1:0] o_last_h_sync
);

  localparam logic [CNT_W-1:0] L_H_TOTAL  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] L_H_ACTIVE = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] L_H_SYNC   = CNT_W'(H_SYNC);

  logic [CNT_W-1:0] r_h_cnt, r_hs_cnt, r_act_cnt;
  logic             r_line_valid;
  logic             r_line_bad;
  logic             w_line_done;
  logic             w_mismatch;

  // A line only counts once a previous hsync edge opened it and it did not overflow.
  assign w_line_done = i_pix_en & i_hs_edge & r_line_valid & (r_h_cnt != CNT_MAX);
  // Blanking lines carry no active pixels, so the active width is checked only on lines that have some.
  assign w_mismatch  = (r_h_cnt != L_H_TOTAL) | (r_hs_cnt != L_H_SYNC) |
                       ((r_act_cnt != '0) & (r_act_cnt != L_H_ACTIVE));

  assign o_line_done = w_line_done;
  assign o_act_line  = (r_act_cnt != '0);
  assign o_line_bad  = r_line_bad;
  assign o_h_ovf     = i_pix_en & ~i_hs_edge & (r_h_cnt >= (CNT_MAX - 1'b1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt         <= '0;
      r_hs_cnt        <= '0;
      r_act_cnt       <= '0;
      r_line_valid    <= 1'b0;
      r_line_bad      <= 1'b0;
      o_last_h_total  <= '0;
      o_last_h_active <= '0;
      o_last_h_sync   <= '0;
    end else if (i_pix_en) begin
      if (i_hs_edge) begin
        r_h_cnt      <= CNT_W'(1);
        r_hs_cnt     <= CNT_W'(1);
        r_act_cnt    <= {{(CNT_W-1){1'b0}}, i_blank_n};
        r_line_valid <= 1'b1;
      end else begin
        r_h_cnt   <= cnt_inc(r_h_cnt, 1'b1);
        r_hs_cnt  <= cnt_inc(r_hs_cnt, i_hs_act);
        r_act_cnt <= cnt_inc(r_act_cnt, i_blank_n);
      end
      if (w_line_done) begin
        o_last_h_total <= r_h_cnt;
        o_last_h_sync  <= r_hs_cnt;
        // Keep the width of the last line that actually had video.
        if (r_act_cnt != '0) o_last_h_active <= r_act_cnt;
      end
      if (i_frame_clr)                 r_line_bad <= w_line_done & w_mismatch;
      else if (w_line_done & w_mismatch) r_line_bad <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: frame geometry, active-pixel signature, per-frame
// reports and lock/error tracking on top of the per-line meter.
module vga_rx_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_TOTAL         = DEF_H_TOTAL,
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int V_TOTAL         = DEF_V_TOTAL,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW,
  parameter int LOCK_FRAMES     = DEF_LOCK_FRAMES
) (
  input  logic        CLOCK_50,
  input  logic        reset_reset_n,
  input  logic        pix_en,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [9:0]  vga_r,
  input  logic [9:0]  vga_g,
  input  logic [9:0]  vga_b,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        locked,
  output logic [11:0] h_total_o,
  output logic [11:0] h_active_o,
  output logic [11:0] h_sync_o,
  output logic [11:0] v_total_o,
  output logic [11:0] v_active_o,
  output logic [11:0] v_sync_o,
  output logic [15:0] checksum,
  output logic [7:0]  err_count
);

  localparam logic             L_POL      = (SYNC_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] L_V_TOTAL  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] L_V_ACTIVE = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] L_V_SYNC   = CNT_W'(V_SYNC);
  localparam logic [7:0]       L_LOCK     = 8'(LOCK_FRAMES);

  mon_state_e       r_state, w_state_nxt;
  logic             r_hs_prev, r_vs_prev;
  logic [CNT_W-1:0] r_v_cnt, r_v_act_cnt, r_v_sync_cnt;
  logic [15:0]      r_sig;
  logic [7:0]       r_good_cnt;

  logic             w_hs_act, w_vs_act, w_hs_edge, w_vs_edge, w_frame_clr;
  logic             w_line_done, w_act_line, w_line_bad, w_h_ovf, w_ovf;
  logic             w_report, w_ovf_evt, w_frame_good;
  logic [CNT_W-1:0] w_last_h_total, w_last_h_active, w_last_h_sync;
  logic [CNT_W-1:0] w_v_cnt_nxt, w_v_act_nxt, w_v_sync_nxt;
  logic [15:0]      w_pix_word, w_sig_base, w_sig_nxt;
  logic [7:0]       w_good_nxt, w_err_nxt;
  logic             w_unused;

  assign w_hs_act    = vga_hs ^ L_POL;
  assign w_vs_act    = vga_vs ^ L_POL;
  assign w_hs_edge   = w_hs_act & ~r_hs_prev;
  assign w_vs_edge   = w_vs_act & ~r_vs_prev;
  assign w_frame_clr = pix_en & w_vs_edge;
  assign w_pix_word  = {vga_r[9:5], vga_g[9:5], vga_b[9:4]};
  assign w_unused    = ^{vga_r[4:0], vga_g[4:0], vga_b[3:0]};

  vga_line_meter #(
    .H_TOTAL (H_TOTAL),
    .H_ACTIVE(H_ACTIVE),
    .H_SYNC  (H_SYNC)
  ) u_line_meter (
    .i_clk          (CLOCK_50),
    .i_rst_n        (reset_reset_n),
    .i_pix_en       (pix_en),
    .i_hs_act       (w_hs_act),
    .i_hs_edge      (w_hs_edge),
    .i_blank_n      (vga_blank_n),
    .i_frame_clr    (w_frame_clr),
    .o_line_done    (w_line_done),
    .o_act_line     (w_act_line),
    .o_line_bad     (w_line_bad),
    .o_h_ovf        (w_h_ovf),
    .o_last_h_total (w_last_h_total),
    .o_last_h_active(w_last_h_active),
    .o_last_h_sync  (w_last_h_sync)
  );

  // The vsync-edge pixel belongs to the new frame: counters restart from zero before it is folded in.
  always_comb begin
    w_v_cnt_nxt  = cnt_inc(w_frame_clr ? '0 : r_v_cnt, w_hs_edge);
    w_v_sync_nxt = cnt_inc(w_frame_clr ? '0 : r_v_sync_cnt, w_hs_edge & w_vs_act);
    w_v_act_nxt  = cnt_inc(w_frame_clr ? '0 : r_v_act_cnt, w_line_done & w_act_line);
    w_sig_base   = w_frame_clr ? 16'h0000 : r_sig;
    w_sig_nxt    = vga_blank_n ? sig_step(w_sig_base, w_pix_word) : w_sig_base;
  end

  assign w_ovf        = w_h_ovf | (pix_en & (w_v_cnt_nxt == CNT_MAX));
  assign w_frame_good = ~w_line_bad & (r_v_cnt == L_V_TOTAL) &
                        (r_v_act_cnt == L_V_ACTIVE) & (r_v_sync_cnt == L_V_SYNC);
  assign w_good_nxt   = (r_good_cnt == 8'hFF) ? r_good_cnt : r_good_cnt + 8'd1;
  assign w_err_nxt    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= SEARCH;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_report    = 1'b0;
    w_ovf_evt   = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_frame_clr) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (w_ovf) begin
          w_state_nxt = SEARCH;
          w_ovf_evt   = 1'b1;
        end else if (w_frame_clr) begin
          w_report = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_hs_prev    <= 1'b0;
      r_vs_prev    <= 1'b0;
      r_v_cnt      <= '0;
      r_v_act_cnt  <= '0;
      r_v_sync_cnt <= '0;
      r_sig        <= '0;
    end else if (pix_en) begin
      r_hs_prev    <= w_hs_act;
      r_vs_prev    <= w_vs_act;
      r_v_cnt      <= w_v_cnt_nxt;
      r_v_act_cnt  <= w_v_act_nxt;
      r_v_sync_cnt <= w_v_sync_nxt;
      r_sig        <= w_sig_nxt;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      locked     <= 1'b0;
      h_total_o  <= '0;
      h_active_o <= '0;
      h_sync_o   <= '0;
      v_total_o  <= '0;
      v_active_o <= '0;
      v_sync_o   <= '0;
      checksum   <= '0;
      err_count  <= '0;
      r_good_cnt <= '0;
    end else begin
      frame_done <= w_report;
      if (w_report) begin
        h_total_o  <= w_last_h_total;
        h_active_o <= w_last_h_active;
        h_sync_o   <= w_last_h_sync;
        v_total_o  <= r_v_cnt;
        v_active_o <= r_v_act_cnt;
        v_sync_o   <= r_v_sync_cnt;
        checksum   <= r_sig;
        frame_ok   <= w_frame_good;
        if (w_frame_good) begin
          r_good_cnt <= w_good_nxt;
          locked     <= (w_good_nxt >= L_LOCK);
        end else begin
          r_good_cnt <= '0;
          locked     <= 1'b0;
          err_count  <= w_err_nxt;
        end
      end else if (w_ovf_evt) begin
        r_good_cnt <= '0;
        locked     <= 1'b0;
        err_count  <= w_err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor on a reduced 20x10 raster so whole
// frames fit in a short run; reports are checked by a separate monitor process.
module tb_vga_rx_monitor;

  localparam int HT = 20, HA = 13, HS = 3, VT = 10, VA = 5, VS = 2;

  logic        CLOCK_50 = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
  logic [9:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        frame_done, frame_ok, locked;
  logic [11:0] h_total_o, h_active_o, h_sync_o, v_total_o, v_active_o, v_sync_o;
  logic [15:0] checksum;
  logic [7:0]  err_count;

  typedef struct {
    logic [11:0] ht, ha, hs, vt, va, vs;
    logic [15:0] sig;
    logic        ok, lck;
    logic [7:0]  err;
  } rep_t;

  rep_t        exp_q[$];
  rep_t        e_mon;
  int          checks = 0, failures = 0;
  bit          toggle = 1'b0;
  bit          fd_prev = 1'b0;
  logic [15:0] model_sig = '0, prev_sig = '0, last_rep_sig = '0;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC(HS),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC(VS),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_reset_n(reset_reset_n), .pix_en(pix_en),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
    .h_total_o(h_total_o), .h_active_o(h_active_o), .h_sync_o(h_sync_o),
    .v_total_o(v_total_o), .v_active_o(v_active_o), .v_sync_o(v_sync_o),
    .checksum(checksum), .err_count(err_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every frame_done pops one expected report; pulse must last one cycle.
  always @(negedge CLOCK_50) begin
    if (fd_prev) chk("frame_done_width", {31'b0, frame_done}, 32'd0);
    fd_prev = frame_done;
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done: actual=1 required=0");
      end else begin
        e_mon = exp_q.pop_front();
        chk("h_total",  32'(h_total_o),  32'(e_mon.ht));
        chk("h_active", 32'(h_active_o), 32'(e_mon.ha));
        chk("h_sync",   32'(h_sync_o),   32'(e_mon.hs));
        chk("v_total",  32'(v_total_o),  32'(e_mon.vt));
        chk("v_active", 32'(v_active_o), 32'(e_mon.va));
        chk("v_sync",   32'(v_sync_o),   32'(e_mon.vs));
        chk("checksum", 32'(checksum),   32'(e_mon.sig));
        chk("frame_ok", 32'(frame_ok),   32'(e_mon.ok));
        chk("locked",   32'(locked),     32'(e_mon.lck));
        chk("err_count",32'(err_count),  32'(e_mon.err));
      end
    end
  end

  task automatic pix(input bit hs, input bit vs, input bit bl,
                     input logic [9:0] rr, input logic [9:0] gg, input logic [9:0] bb);
    vga_hs = ~hs; vga_vs = ~vs; vga_blank_n = bl;
    vga_r = rr; vga_g = gg; vga_b = bb;
    pix_en = 1'b1;
    @(posedge CLOCK_50); #1;
    if (toggle) begin
      // Garbage on the idle strobe must be ignored.
      pix_en = 1'b0;
      vga_hs = ~vga_hs; vga_vs = ~vga_vs; vga_blank_n = ~vga_blank_n; vga_r = ~vga_r;
      @(posedge CLOCK_50); #1;
    end
  endtask

  task automatic idle(input int n);
    pix_en = 1'b0;
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Sends one raster starting with the vsync-edge pixel; optionally expects the report of the previous frame.
  task automatic frame(input int nlines, input int long_line, input bit cc,
                       input bit exp_prev, input bit ok, input bit lck, input int errc);
    rep_t        e;
    bit          act;
    logic [9:0]  rr, gg, bb;
    int          hmax;
    if (exp_prev) begin
      e.ht = 12'(HT); e.ha = 12'(HA); e.hs = 12'(HS);
      e.vt = 12'(VT); e.va = 12'(VA); e.vs = 12'(VS);
      e.sig = prev_sig; e.ok = ok; e.lck = lck; e.err = 8'(errc);
      last_rep_sig = prev_sig;
      exp_q.push_back(e);
    end
    model_sig = '0;
    for (int v = 0; v < nlines; v++) begin
      hmax = (v == long_line) ? HT + 1 : HT;
      for (int h = 0; h < hmax; h++) begin
        act = (v >= 3) && (v < 3 + VA) && (h >= 5) && (h < 5 + HA);
        if (cc) begin
          rr = 10'h3FF; gg = 10'h3FF; bb = 10'h3FF;
        end else begin
          rr = 10'(h * 37 + v * 11 + 1);
          gg = 10'((h * 5) ^ (v * 91));
          bb = 10'(v * 53 + h * 3 + 7);
        end
        if (act) model_sig = {model_sig[14:0], model_sig[15]} ^ {rr[9:5], gg[9:5], bb[9:4]};
        pix(h < HS, v < VS, act, rr, gg, bb);
      end
    end
    prev_sig = model_sig;
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_ok",   32'(frame_ok),   32'd0);
    chk("rst_locked",     32'(locked),     32'd0);
    chk("rst_err_count",  32'(err_count),  32'd0);
    chk("rst_h_total",    32'(h_total_o),  32'd0);
    chk("rst_checksum",   32'(checksum),   32'd0);
    reset_reset_n = 1'b1;
    idle(2);

    // Ideal stream: first edge silent, then reports, lock after two good frames.
    frame(VT, -1, 0, 0, 0, 0, 0);
    frame(VT, -1, 0, 1, 1, 0, 0);
    frame(VT, -1, 0, 1, 1, 1, 0);
    // Frame with one 21-pixel line, then relock.
    frame(VT, 4,  0, 1, 1, 1, 0);
    frame(VT, -1, 0, 1, 0, 0, 1);
    frame(VT, -1, 1, 1, 1, 0, 1);
    // 65 all-ones words: odd count of 16'hFFFF through rotate-XOR leaves 16'hFFFF.
    prev_sig = 16'hFFFF;
    toggle = 1'b1;
    frame(VT, -1, 0, 1, 1, 1, 1);
    frame(VT, -1, 0, 1, 1, 1, 1);
    toggle = 1'b0;

    // No hsync for long enough to overflow the line counter.
    for (int i = 0; i < 4100; i++) pix(0, 0, 0, 10'h155, 10'h2AA, 10'h0F0);
    idle(3);
    chk("ovf_err_count", 32'(err_count), 32'd2);
    chk("ovf_locked",    32'(locked),    32'd0);
    chk("ovf_hold_ok",   32'(frame_ok),  32'd1);
    chk("ovf_hold_ht",   32'(h_total_o), 32'(HT));
    chk("ovf_hold_vt",   32'(v_total_o), 32'(VT));
    chk("ovf_hold_sig",  32'(checksum),  32'(last_rep_sig));

    frame(VT, -1, 0, 0, 0, 0, 0);
    frame(5,  -1, 0, 1, 1, 0, 2);

    // Mid-frame reset clears everything immediately.
    reset_reset_n = 1'b0;
    pix_en = 1'b0;
    #1;
    chk("mid_rst_frame_ok",  32'(frame_ok),   32'd0);
    chk("mid_rst_err_count", 32'(err_count),  32'd0);
    chk("mid_rst_h_total",   32'(h_total_o),  32'd0);
    chk("mid_rst_v_active",  32'(v_active_o), 32'd0);
    chk("mid_rst_checksum",  32'(checksum),   32'd0);
    idle(2);
    reset_reset_n = 1'b1;
    idle(2);

    frame(VT, -1, 0, 0, 0, 0, 0);
    frame(VT, -1, 0, 1, 1, 0, 0);
    frame(VT, -1, 0, 1, 1, 1, 0);
    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
